vpu_dst_operand_packer: RTL
===========================

// Module: vpu_dst_operand_packer
// PURPOSE
//  Result-side counterpart of the source operand queue. Collects narrow per-beat lane results
//  (OPERAND_WIDTH*VLANE_CNT bits) from the vector lanes and packs them into DIM_SIZE-wide words.
//  Queues packed words in a DEPTH-entry FIFO for the SRAM write port.
//  Supports flush of a partially packed word with a per-beat valid mask.
// PARAMETERS
//  DIM_SIZE       512  wide word width (SRAM write data)
//  OPERAND_WIDTH  32   bits per lane element
//  VLANE_CNT      4    lanes; narrow beat NW = OPERAND_WIDTH*VLANE_CNT (128)
//  DEPTH_LG2      2    log2 of wide-word FIFO depth (DEPTH = 4)
//  derived        RATIO = DIM_SIZE/NW (4); DIM_SIZE % NW == 0 and RATIO >= 2 required
// PORTS
//  clk        in   1         single clock, all logic rising-edge
//  rst_n      in   1         asynchronous active-low reset
//  wren_i     in   1         lane beat valid; accepted when !wrfull_o
//  wdata_i    in   NW        lane beat data
//  flush_i    in   1         commit partial word; accepted when !wrfull_o
//  wrempty_o  out  1         FIFO empty AND no beats pending in packer
//  wrfull_o   out  1         FIFO holds DEPTH words
//  rden_i     in   1         pop head word; ignored when rdempty_o
//  rdata_o    out  DIM_SIZE  head word (show-ahead)
//  rdmask_o   out  RATIO     head word beat-valid mask; bit k covers bits [k*NW +: NW]
//  rdempty_o  out  1         FIFO empty
//  rdfull_o   out  1         same as wrfull_o
// BEHAVIOUR
//  Reset (async assert, sync release): beat_cnt=0, pack reg=0, FIFO ptrs/count=0.
//   Outputs: wrempty_o=1, rdempty_o=1, wrfull_o=0, rdfull_o=0, rdata_o=0, rdmask_o=0.
//   Reset mid-packing discards pending beats and all FIFO contents.
//  Packing: accepted beat (wren_i & !wrfull_o) lands in slot beat_cnt, beat 0 = LSBs.
//   beat_cnt increments and wraps RATIO-1 -> 0.
//   On the beat at slot RATIO-1, the assembled word (this beat included) is written to the FIFO
//   tail with mask all-ones. The pack reg clears the same cycle.
//  Flush: accepted flush (flush_i & !wrfull_o) with pending beats (beat_cnt!=0, or a beat
//   accepted this cycle) writes the partial word to FIFO.
//   Unfilled slots are zero, and mask bits are set for filled slots only.
//   The packer then resets, with beat_cnt=0.
//   A beat accepted in the same cycle is included in the flushed word.
//   If that beat completes the word, the mask is all-ones and only one word is written.
//   Flush with nothing pending is a no-op.
//  Backpressure: wrfull_o = (count==DEPTH). While full, wren_i and flush_i are both ignored,
//   even for non-completing beats. The producer holds data/flush until accepted.
//  Read: rdata_o/rdmask_o show the FIFO head combinationally, and are forced to 0 while rdempty_o=1.
//   Pop happens when rden_i & !rdempty_o. rden_i when empty is ignored, with no state change.
//  Latency: a word completed at cycle t is visible with rdempty_o=0 at t+1.
//   wrfull_o/rdempty_o/wrempty_o are registered-state functions, updated the cycle after
//   the push/pop.
//  Simultaneous push+pop: count unchanged, pointers both advance, and the data is correct.
//   A pop while full frees a slot, so wrfull_o deasserts at t+1.
//   The same-cycle push is still blocked by wrfull_o.
//  Pointers are DEPTH_LG2+1 bits with wrap bit; full/empty come from a count register.
//  wrempty_o = rdempty_o & (beat_cnt==0). It drops the cycle after the first beat is accepted.
// TESTING
//  1 Reset: after rst_n low, outputs = 1,0,1,0, data/mask 0; rst_n asserted mid-packing clears
//    beat_cnt (next word starts at slot 0).
//  2 Pack: beats 0x0..01..0x0..04 on 4 consecutive cycles -> at t+1 rdempty_o=0,
//    rdata_o = {04,03,02,01} (beat0 LSBs), rdmask_o=4'b1111; rden_i -> rdempty_o=1 next cycle.
//  3 Flush: 2 beats A,B then flush_i -> head = {0,0,B,A}, rdmask_o=4'b0011;
//    flush_i with wren_i on beat 3 -> one word, mask 4'b1111; flush with nothing pending -> no write.
//  4 Full: push 4 words with no reads -> wrfull_o=1; a further beat is not accepted and
//    beat_cnt is unchanged. One pop -> wrfull_o=0 next cycle; the held beat is then accepted.
//  5 Concurrent: stream beats continuously while popping each word -> no loss or duplication,
//    ordering preserved, FIFO count never exceeds 1.
//  6 Underflow: rden_i with rdempty_o=1 for 3 cycles -> pointers/count unchanged, rdata_o=0.

Source files
------------

// File: rtl/vpu_dst_operand_packer.sv
// Result-side operand packer: gathers NW-bit lane beats into DIM_SIZE-bit words and
// queues them (with a per-beat valid mask) in a small show-ahead FIFO for the SRAM write port.
module vpu_dst_operand_packer #(
  parameter int DIM_SIZE      = 512,
  parameter int OPERAND_WIDTH = 32,
  parameter int VLANE_CNT     = 4,
  parameter int DEPTH_LG2     = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   wren_i,
  input  logic [OPERAND_WIDTH*VLANE_CNT-1:0]     wdata_i,
  input  logic                                   flush_i,
  output logic                                   wrempty_o,
  output logic                                   wrfull_o,
  input  logic                                   rden_i,
  output logic [DIM_SIZE-1:0]                    rdata_o,
  output logic [DIM_SIZE/(OPERAND_WIDTH*VLANE_CNT)-1:0] rdmask_o,
  output logic                                   rdempty_o,
  output logic                                   rdfull_o
);

  localparam int NW    = OPERAND_WIDTH * VLANE_CNT;
  localparam int RATIO = DIM_SIZE / NW;
  localparam int DEPTH = 1 << DEPTH_LG2;
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int PTR_W = DEPTH_LG2 + 1;

  logic [CNT_W-1:0]    r_beat_cnt;
  logic [DIM_SIZE-1:0] r_pack;
  logic [DIM_SIZE-1:0] r_mem_data [DEPTH];
  logic [RATIO-1:0]    r_mem_mask [DEPTH];
  logic [PTR_W-1:0]    r_wptr;
  logic [PTR_W-1:0]    r_rptr;
  logic [PTR_W-1:0]    r_count;

  logic                w_full;
  logic                w_empty;
  logic                w_beat_acc;
  logic                w_flush_acc;
  logic                w_complete;
  logic                w_push;
  logic                w_pop;
  logic [CNT_W:0]      w_filled;
  logic [DIM_SIZE-1:0] w_word;
  logic [RATIO-1:0]    w_mask;
  logic                w_unused_wrap;

  assign w_full      = (r_count == PTR_W'(DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_beat_acc  = wren_i & ~w_full;
  assign w_flush_acc = flush_i & ~w_full;
  assign w_filled    = {1'b0, r_beat_cnt} + {{CNT_W{1'b0}}, w_beat_acc};
  assign w_complete  = w_beat_acc & (r_beat_cnt == CNT_W'(RATIO - 1));
  // A completing beat together with a flush still yields exactly one push.
  assign w_push      = w_complete | (w_flush_acc & (w_filled != '0));
  assign w_pop       = rden_i & ~w_empty;

  // NOTE: every always_comb output gets a default before any conditional write, so no latch is inferred.
  always_comb begin
    w_word = r_pack;
    w_mask = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (w_beat_acc && (r_beat_cnt == CNT_W'(k)))
        w_word[k*NW +: NW] = wdata_i;
      w_mask[k] = ((CNT_W+1)'(k) < w_filled);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_cnt <= '0;
      r_pack     <= '0;
    end else if (w_push) begin
      r_beat_cnt <= '0;
      r_pack     <= '0;
    end else if (w_beat_acc) begin
      r_beat_cnt <= r_beat_cnt + 1'b1;
      r_pack     <= w_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; stale entries are never visible because the read side is gated by empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wptr[DEPTH_LG2-1:0]] <= w_word;
      r_mem_mask[r_wptr[DEPTH_LG2-1:0]] <= w_mask;
    end
  end

  // Wrap bits are kept for debug visibility; occupancy comes from r_count.
  assign w_unused_wrap = r_wptr[DEPTH_LG2] ^ r_rptr[DEPTH_LG2];

  assign rdempty_o = w_empty;
  assign wrfull_o  = w_full;
  assign rdfull_o  = w_full;
  assign wrempty_o = w_empty & (r_beat_cnt == '0);
  assign rdata_o   = w_empty ? '0 : r_mem_data[r_rptr[DEPTH_LG2-1:0]];
  assign rdmask_o  = w_empty ? '0 : r_mem_mask[r_rptr[DEPTH_LG2-1:0]];

endmodule
